// File: rtl/agc_sequencer_if.sv
// Bundle between the AGC sequencer and its environment (register core on one side,
// per-channel AGC cores on the other). meas_count exists only with AGC_MEAS_COUNT_EN.
interface agc_sequencer_if #(
  parameter int unsigned SqBits = 24,
  parameter int unsigned PrBits = 21
);
  logic              enable;
  logic              lfsr_reset;
  logic              agc_tick;
  logic              agc_ce;
  logic              agc_rst;
  logic [SqBits-1:0] sq_accum;
  logic [PrBits-1:0] gt_accum;
  logic [PrBits-1:0] lt_accum;
  logic [SqBits-1:0] sq;
  logic [PrBits-1:0] gt;
  logic [PrBits-1:0] lt;
  logic              meas_valid;
  logic              meas_ack;
  logic              overrun;
  logic [16:0]       scale;
  logic              scale_wr;
  logic [7:0]        offset;
  logic              offset_wr;
  logic              apply;
  logic [16:0]       agc_scale;
  logic [7:0]        agc_offset;
  logic              agc_scale_ce;
  logic              agc_offset_ce;
  logic              agc_apply;
`ifdef AGC_MEAS_COUNT_EN
  logic [15:0]       meas_count;
`endif

  // Environment side: host registers and AGC cores.
  modport master (
    output enable, lfsr_reset, sq_accum, gt_accum, lt_accum, meas_ack,
    output scale, scale_wr, offset, offset_wr, apply,
`ifdef AGC_MEAS_COUNT_EN
    input  meas_count,
`endif
    input  agc_tick, agc_ce, agc_rst, sq, gt, lt, meas_valid, overrun,
    input  agc_scale, agc_offset, agc_scale_ce, agc_offset_ce, agc_apply
  );

  // Sequencer side.
  modport slave (
    input  enable, lfsr_reset, sq_accum, gt_accum, lt_accum, meas_ack,
    input  scale, scale_wr, offset, offset_wr, apply,
`ifdef AGC_MEAS_COUNT_EN
    output meas_count,
`endif
    output agc_tick, agc_ce, agc_rst, sq, gt, lt, meas_valid, overrun,
    output agc_scale, agc_offset, agc_scale_ce, agc_offset_ce, agc_apply
  );
endinterface

// File: rtl/agc_sequencer.sv
// AGC sequencer: measurement-window timing, accumulator capture with valid/ack, and
// window-aligned gain updates. Define AGC_MEAS_COUNT_EN to add the meas_count capture counter.
module agc_sequencer #(
  parameter int unsigned SqBits  = 24,
  parameter int unsigned PrBits  = 21,
  parameter int unsigned LenLog2 = 17,
  parameter int unsigned AccLat  = 3
) (
  input logic            clk_i,
  input logic            rstn_i,
  agc_sequencer_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StTick, StRun, StSettle, StCapture} state_e;

  localparam logic [LenLog2:0] RunLen    = {1'b1, {LenLog2{1'b0}}};
  localparam logic [LenLog2:0] RunFirst  = {{LenLog2{1'b0}}, 1'b1};
  localparam logic [3:0]       SettleLen = 4'(AccLat);

  state_e           st_q;
  logic [LenLog2:0] run_cnt_q;
  logic [3:0]       set_cnt_q;
  logic             tick_q, ce_q, apply_q, apply_pend_q;
  logic             capture;

  // Window FSM; every strobe is registered one cycle behind the state it marks.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q         <= StIdle;
      run_cnt_q    <= '0;
      set_cnt_q    <= '0;
      tick_q       <= 1'b0;
      ce_q         <= 1'b0;
      apply_q      <= 1'b0;
      apply_pend_q <= 1'b0;
    end else begin
      tick_q  <= (st_q == StTick);
      // Gated by enable so an abort drops ce on the very next cycle.
      ce_q    <= (st_q == StRun) && bus_io.enable;
      apply_q <= (st_q == StTick) && apply_pend_q;
      // A request arriving on the consuming cycle survives for the next window.
      if (bus_io.apply) begin
        apply_pend_q <= 1'b1;
      end else if (st_q == StTick) begin
        apply_pend_q <= 1'b0;
      end

      unique case (st_q)
        StIdle: begin
          if (bus_io.enable) st_q <= StTick;
        end
        StTick: begin
          if (!bus_io.enable) begin
            st_q <= StIdle;
          end else begin
            st_q      <= StRun;
            run_cnt_q <= RunFirst;
          end
        end
        StRun: begin
          if (!bus_io.enable) begin
            st_q <= StIdle;
          end else if (run_cnt_q == RunLen) begin
            st_q      <= StSettle;
            set_cnt_q <= 4'd1;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (!bus_io.enable) begin
            st_q <= StIdle;
          end else if (set_cnt_q == SettleLen) begin
            st_q <= StCapture;
          end else begin
            set_cnt_q <= set_cnt_q + 4'd1;
          end
        end
        StCapture: begin
          st_q <= bus_io.enable ? StTick : StIdle;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

  assign capture = (st_q == StCapture);

  logic [SqBits-1:0] sq_q;
  logic [PrBits-1:0] gt_q, lt_q;
  logic              valid_q, overrun_q, enable_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sq_q      <= '0;
      gt_q      <= '0;
      lt_q      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      enable_q <= bus_io.enable;
      if (capture) begin
        sq_q    <= bus_io.sq_accum;
        gt_q    <= bus_io.gt_accum;
        lt_q    <= bus_io.lt_accum;
        valid_q <= 1'b1;
        if (valid_q && !bus_io.meas_ack) overrun_q <= 1'b1;
      end else if (bus_io.meas_ack) begin
        valid_q <= 1'b0;
      end
      if (bus_io.enable && !enable_q) overrun_q <= 1'b0;
    end
  end

`ifdef AGC_MEAS_COUNT_EN
  logic [15:0] meas_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meas_cnt_q <= '0;
    end else if (capture) begin
      meas_cnt_q <= meas_cnt_q + 16'd1;
    end
  end

  assign bus_io.meas_count = meas_cnt_q;
`endif

  logic [16:0] scale_q;
  logic [7:0]  offset_q;
  logic        scale_ce_q, offset_ce_q, rst_q;

  // Host writes pass through in any FSM state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scale_q     <= '0;
      offset_q    <= '0;
      scale_ce_q  <= 1'b0;
      offset_ce_q <= 1'b0;
      rst_q       <= 1'b0;
    end else begin
      scale_ce_q  <= bus_io.scale_wr;
      offset_ce_q <= bus_io.offset_wr;
      rst_q       <= bus_io.lfsr_reset;
      if (bus_io.scale_wr)  scale_q  <= bus_io.scale;
      if (bus_io.offset_wr) offset_q <= bus_io.offset;
    end
  end

  assign bus_io.agc_tick      = tick_q;
  assign bus_io.agc_ce        = ce_q;
  assign bus_io.agc_rst       = rst_q;
  assign bus_io.agc_apply     = apply_q;
  assign bus_io.sq            = sq_q;
  assign bus_io.gt            = gt_q;
  assign bus_io.lt            = lt_q;
  assign bus_io.meas_valid    = valid_q;
  assign bus_io.overrun       = overrun_q;
  assign bus_io.agc_scale     = scale_q;
  assign bus_io.agc_offset    = offset_q;
  assign bus_io.agc_scale_ce  = scale_ce_q;
  assign bus_io.agc_offset_ce = offset_ce_q;

endmodule

// File: tb/tb_agc_sequencer.sv
// Self-checking bench for agc_sequencer with LenLog2=4, AccLat=3: table vectors,
// directed window sequences, then randomized traffic against a window-arithmetic model.
module tb_agc_sequencer;

  localparam int Period = 16 + 3 + 2;  // 2**LenLog2 + AccLat + 2

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  agc_sequencer_if #(.SqBits(24), .PrBits(21)) bus ();

  agc_sequencer #(
    .SqBits (24),
    .PrBits (21),
    .LenLog2(4),
    .AccLat (3)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {tick, ce, rst, valid, overrun, scale_ce, offset_ce, apply}
  function automatic logic [7:0] strobes();
    return {bus.agc_tick, bus.agc_ce, bus.agc_rst, bus.meas_valid, bus.overrun,
            bus.agc_scale_ce, bus.agc_offset_ce, bus.agc_apply};
  endfunction

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.agc_tick && n < maxc);
  endtask

  typedef struct {
    logic        sw;
    logic [16:0] s;
    logic        ow;
    logic [7:0]  o;
    logic        lr;
    logic [16:0] e_scale;
    logic        e_sce;
    logic [7:0]  e_off;
    logic        e_oce;
    logic        e_rst;
  } wr_vec_t;

  wr_vec_t tbl[6];

  // Model state for the randomized phase.
  bit          m_valid, m_over, m_sce, m_oce, m_rst, m_apply, m_tick, m_ce;
  logic [23:0] m_sq;
  logic [20:0] m_gt, m_lt;
  logic [16:0] m_scale;
  logic [7:0]  m_off;
  int          req_q[$];
`ifdef AGC_MEAS_COUNT_EN
  logic [15:0] m_cnt;
`endif

  initial begin
    int  n, cnt, ce_cnt;
    bit  seen;

    bus.enable = 0; bus.lfsr_reset = 0; bus.sq_accum = '0; bus.gt_accum = '0;
    bus.lt_accum = '0; bus.meas_ack = 0; bus.scale = '0; bus.scale_wr = 0;
    bus.offset = '0; bus.offset_wr = 0; bus.apply = 0;

    tbl[0] = '{1, 17'h10000, 0, 8'h55, 0, 17'h10000, 1, 8'h00, 0, 0};
    tbl[1] = '{0, 17'h1FFFF, 1, 8'hA5, 1, 17'h10000, 0, 8'hA5, 1, 1};
    tbl[2] = '{0, 17'h00000, 0, 8'hFF, 0, 17'h10000, 0, 8'hA5, 0, 0};
    tbl[3] = '{1, 17'h1FFFF, 1, 8'h00, 1, 17'h1FFFF, 1, 8'h00, 1, 1};
    tbl[4] = '{1, 17'h00001, 0, 8'h3C, 0, 17'h00001, 1, 8'h00, 0, 0};
    tbl[5] = '{1, 17'h10000, 1, 8'h80, 0, 17'h10000, 1, 8'h80, 1, 0};

    #2 rstn = 0;
    repeat (3) step();
    check("reset_strobes", strobes(), 8'h00);
    check("reset_meas", {bus.sq, bus.gt}, '0);
    check("reset_cfg", {bus.agc_scale, bus.agc_offset, bus.lt}, '0);
    rstn = 1;
    step();

    // Host write / LFSR pass-through, FSM must stay idle.
    foreach (tbl[i]) begin
      bus.scale_wr = tbl[i].sw; bus.scale = tbl[i].s;
      bus.offset_wr = tbl[i].ow; bus.offset = tbl[i].o;
      bus.lfsr_reset = tbl[i].lr;
      step();
      check($sformatf("wr_scale[%0d]", i), bus.agc_scale, tbl[i].e_scale);
      check($sformatf("wr_offset[%0d]", i), bus.agc_offset, tbl[i].e_off);
      check($sformatf("wr_strobes[%0d]", i),
            {bus.agc_tick, bus.agc_ce, bus.agc_scale_ce, bus.agc_offset_ce, bus.agc_rst},
            {2'b00, tbl[i].e_sce, tbl[i].e_oce, tbl[i].e_rst});
    end
    bus.scale_wr = 0; bus.offset_wr = 0; bus.lfsr_reset = 0;

    // Apply while idle must wait for the first tick.
    bus.apply = 1;
    step();
    bus.apply = 0;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.agc_apply) seen = 1;
    end
    check("apply_idle_held", seen, 0);

    bus.sq_accum = 24'h001234;
    bus.enable = 1;
    wait_tick(5, n);
    check("first_tick_latency", n, 2);
    check("apply_on_first_tick", bus.agc_apply, 1);

    cnt = 0; ce_cnt = 0;
    do begin
      step();
      cnt++;
      if (bus.agc_ce) ce_cnt++;
    end while (!bus.meas_valid && cnt < 30);
    check("capture_latency", cnt, 20);
    check("ce_cycles", ce_cnt, 16);
    check("capture_sq", bus.sq, 24'h001234);

    bus.sq_accum = 24'h00ABCD;
    wait_tick(30, n);
    check("tick_period", cnt + n, Period);
    check("apply_not_repeated", bus.agc_apply, 0);

    repeat (5) step();
    bus.apply = 1;
    step();
    bus.apply = 0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!bus.overrun && cnt < 30);
    check("second_capture_sq", bus.sq, 24'h00ABCD);
    check("overrun_valid", {bus.meas_valid, bus.overrun}, 2'b11);
    wait_tick(30, n);
    check("apply_mid_run", {bus.agc_tick, bus.agc_apply}, 2'b11);
    wait_tick(30, n);
    check("apply_exactly_once", {bus.agc_tick, bus.agc_apply}, 2'b10);

    bus.meas_ack = 1;
    step();
    bus.meas_ack = 0;
    check("ack_clears_valid", {bus.meas_valid, bus.overrun}, 2'b01);

    // Abort during the 8th ce cycle of this window.
    cnt = bus.agc_ce ? 1 : 0;
    n = 0;
    while (cnt < 8 && n < 20) begin
      step();
      n++;
      if (bus.agc_ce) cnt++;
    end
    bus.enable = 0;
    step();
    check("abort_ce_off", bus.agc_ce, 0);
    seen = 0;
    repeat (30) begin
      step();
      if (bus.agc_tick || bus.agc_ce || bus.meas_valid) seen = 1;
    end
    check("abort_no_capture", seen, 0);
    check("overrun_held_idle", bus.overrun, 1);

    bus.meas_ack = 1;
    step();
    bus.meas_ack = 0;
    check("ack_when_invalid", {bus.meas_valid, bus.overrun}, 2'b01);

    bus.enable = 1;
    step();
    check("overrun_clear_on_enable", bus.overrun, 0);

    wait_tick(5, n);
    repeat (6) step();
    check("mid_run_ce", bus.agc_ce, 1);
    #2 rstn = 0;
    #1;
    check("reset_mid_run_strobes", strobes(), 8'h00);
    check("reset_mid_run_data", {bus.sq, bus.agc_scale, bus.agc_offset}, '0);
    bus.enable = 0;
    @(posedge clk);
    #1 rstn = 1;
    step();

    // Randomized traffic; first tick lands in cycle 2 relative to enable.
    m_valid = 0; m_over = 0; m_sq = '0; m_gt = '0; m_lt = '0;
    m_scale = '0; m_off = '0;
`ifdef AGC_MEAS_COUNT_EN
    m_cnt = '0;
`endif
    for (int i = 0; i < 9 * Period; i++) begin
      int  j, k, kc;
      bit  cap, ack;
      j  = i + 1;
      k  = (j - 2) % Period;
      kc = (i - 2) % Period;
      cap = (i >= 2) && (kc == Period - 2);
      ack = ($urandom_range(0, 7) == 0) || (cap && (((i - 2) / Period) % 2 == 1));

      bus.enable     = 1;
      bus.sq_accum   = 24'($urandom());
      bus.gt_accum   = 21'($urandom());
      bus.lt_accum   = 21'($urandom());
      bus.meas_ack   = ack;
      bus.apply      = ($urandom_range(0, 24) == 0);
      bus.scale_wr   = ($urandom_range(0, 5) == 0);
      bus.scale      = 17'($urandom());
      bus.offset_wr  = ($urandom_range(0, 5) == 0);
      bus.offset     = 8'($urandom());
      bus.lfsr_reset = ($urandom_range(0, 9) == 0);

      m_tick  = (j >= 2) && (k == 0);
      m_ce    = (j >= 2) && (k >= 1) && (k <= 16);
      m_apply = 0;
      if (m_tick) begin
        while (req_q.size() > 0 && req_q[0] <= j - 2) begin
          m_apply = 1;
          void'(req_q.pop_front());
        end
      end
      if (bus.apply) req_q.push_back(i);

      if (cap) begin
        if (m_valid && !ack) m_over = 1;
        m_valid = 1;
        m_sq = bus.sq_accum; m_gt = bus.gt_accum; m_lt = bus.lt_accum;
`ifdef AGC_MEAS_COUNT_EN
        m_cnt = m_cnt + 16'd1;
`endif
      end else if (ack) begin
        m_valid = 0;
      end
      m_sce = bus.scale_wr;
      m_oce = bus.offset_wr;
      m_rst = bus.lfsr_reset;
      if (bus.scale_wr) m_scale = bus.scale;
      if (bus.offset_wr) m_off = bus.offset;

      step();
      check($sformatf("rnd_strobes[%0d]", j), strobes(),
            {m_tick, m_ce, m_rst, m_valid, m_over, m_sce, m_oce, m_apply});
      check($sformatf("rnd_sq[%0d]", j), bus.sq, m_sq);
      check($sformatf("rnd_gt_lt[%0d]", j), {bus.gt, bus.lt}, {m_gt, m_lt});
      check($sformatf("rnd_cfg[%0d]", j), {bus.agc_scale, bus.agc_offset}, {m_scale, m_off});
`ifdef AGC_MEAS_COUNT_EN
      check($sformatf("rnd_count[%0d]", j), bus.meas_count, m_cnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
